// File: rtl/lib_switchblock_pkg.sv
// Shared types for the switch-block signal path: biquad FSM states, coefficient
// slot indices and the power-up (passthrough) coefficient values.
package lib_switchblock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC0,
        ST_MAC1,
        ST_MAC2,
        ST_MAC3,
        ST_MAC4,
        ST_OUT
    } biquad_state_e;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    localparam int NUM_COEF = 5;

    // Passthrough bank: b0 = 1.0 in the given fractional format, everything else zero.
    function automatic logic [31:0] default_coef(input int idx, input int frac);
        return (idx == int'(B0)) ? (32'd1 << frac) : 32'd0;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Signed coefficient x sample product, sign-extended into an accumulator register
// that can be cleared, added to or subtracted from once per cycle.
module biquad_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = COEF_W + DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod     = coef * data;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
        end
    end

endmodule

// File: rtl/biquad_notch_tdm.sv
// Multi-channel DF-I biquad notch sharing one MAC across NCH channels.
// Define NOTCH_SATURATE_EN to clamp the output (and stored y1) instead of wrapping.
module biquad_notch_tdm
    import lib_switchblock_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  COEF_W    = 18,
    parameter int  COEF_FRAC = 16,
    parameter int  NCH       = 4,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CH_W-1:0]   in_chan_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CH_W-1:0]   out_chan_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              coef_we_i,
    input  logic [2:0]        coef_addr_i,
    input  logic [COEF_W-1:0] coef_wdata_i,
    input  logic              coef_commit_i,
    input  logic              clear_i,
    output logic              busy_o
);

    localparam int ACC_W = DATA_W + COEF_W + 3;

    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX      = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN      = ~Y_MAX;

    biquad_state_e state;

    logic signed [DATA_W-1:0] x_cur, x1_op, x2_op, y1_op, y2_op;
    logic signed [DATA_W-1:0] x1_h [NCH];
    logic signed [DATA_W-1:0] x2_h [NCH];
    logic signed [DATA_W-1:0] y1_h [NCH];
    logic signed [DATA_W-1:0] y2_h [NCH];

    logic signed [COEF_W-1:0] shadow      [NUM_COEF];
    logic signed [COEF_W-1:0] shadow_next [NUM_COEF];
    logic signed [COEF_W-1:0] active      [NUM_COEF];
    logic                     commit_pending;
    logic                     do_copy;

    logic                     accept, chan_ok, out_fire, kill;
    logic                     mac_en, mac_sub;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_data;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] y_red;

    // Round half up, drop the fractional bits, then fit the result into DATA_W.
    function automatic logic signed [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] acc_v);
        logic signed [ACC_W-1:0] scaled;
        scaled = (acc_v + ROUND_HALF) >>> COEF_FRAC;
`ifdef NOTCH_SATURATE_EN
        if (scaled > Y_MAX) begin
            return Y_MAX[DATA_W-1:0];
        end else if (scaled < Y_MIN) begin
            return Y_MIN[DATA_W-1:0];
        end
`endif
        return scaled[DATA_W-1:0];
    endfunction

    assign chan_ok    = 32'(in_chan_i) < NCH;
    assign accept     = in_valid_i && in_ready_o;
    assign out_fire   = (state == ST_OUT) && out_ready_i;
    assign y_red      = reduce(acc);
    assign out_data_o = y_red;

    // NOTE: sequential state uses non-blocking assignments so every register in the
    // block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_chan_o  <= '0;
            x_cur       <= '0;
            x1_op       <= '0;
            x2_op       <= '0;
            y1_op       <= '0;
            y2_op       <= '0;
            kill        <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    in_ready_o <= 1'b1;
                    // An out-of-range channel is swallowed here without leaving IDLE.
                    if (accept && chan_ok) begin
                        state      <= ST_MAC0;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        out_chan_o <= in_chan_i;
                        x_cur      <= in_data_i;
                        x1_op      <= x1_h[in_chan_i];
                        x2_op      <= x2_h[in_chan_i];
                        y1_op      <= y1_h[in_chan_i];
                        y2_op      <= y2_h[in_chan_i];
                        kill       <= clear_i;
                    end
                end
                ST_MAC0: state <= ST_MAC1;
                ST_MAC1: state <= ST_MAC2;
                ST_MAC2: state <= ST_MAC3;
                ST_MAC3: state <= ST_MAC4;
                ST_MAC4: begin
                    state       <= ST_OUT;
                    out_valid_o <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state       <= ST_IDLE;
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (state != ST_IDLE && clear_i) begin
                kill <= 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        mac_en   = 1'b1;
        mac_sub  = 1'b0;
        mac_coef = active[B0];
        mac_data = x_cur;
        unique case (state)
            ST_MAC0: ;
            ST_MAC1: begin
                mac_coef = active[B1];
                mac_data = x1_op;
            end
            ST_MAC2: begin
                mac_coef = active[B2];
                mac_data = x2_op;
            end
            ST_MAC3: begin
                mac_coef = active[A1];
                mac_data = y1_op;
                mac_sub  = 1'b1;
            end
            ST_MAC4: begin
                mac_coef = active[A2];
                mac_data = y2_op;
                mac_sub  = 1'b1;
            end
            default: mac_en = 1'b0;
        endcase
    end

    biquad_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk_i),
        .reset (reset_i),
        .clr   (accept && chan_ok),
        .en    (mac_en),
        .sub   (mac_sub),
        .coef  (mac_coef),
        .data  (mac_data),
        .acc   (acc)
    );

    // NOTE: the histories are reset like ordinary flops because reset must leave every
    // channel at zero in one cycle; a RAM-based history would need a clearing sweep.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            for (int c = 0; c < NCH; c++) begin
                x1_h[c] <= '0;
                x2_h[c] <= '0;
                y1_h[c] <= '0;
                y2_h[c] <= '0;
            end
        end else if (out_fire && !kill) begin
            x2_h[out_chan_o] <= x1_h[out_chan_o];
            x1_h[out_chan_o] <= x_cur;
            y2_h[out_chan_o] <= y1_h[out_chan_o];
            y1_h[out_chan_o] <= y_red;
        end
    end

    // A same-cycle write is visible to a same-cycle commit through shadow_next.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (coef_we_i && coef_addr_i == 3'(k)) begin
                shadow_next[k] = coef_wdata_i;
            end
        end
    end

    assign do_copy = (coef_commit_i && state == ST_IDLE) ||
                     (out_fire && (commit_pending || coef_commit_i));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                shadow[k] <= COEF_W'(default_coef(k, COEF_FRAC));
                active[k] <= COEF_W'(default_coef(k, COEF_FRAC));
            end
            commit_pending <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (do_copy) begin
                active         <= shadow_next;
                commit_pending <= 1'b0;
            end else if (coef_commit_i) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule
